// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - alu_mc operation encodings, FSM state type and operand helper.
// ALU_MC_FAST_MUL_EN drops the MUL state from the state type.
package alu_pkg;

    localparam logic [4:0] ALU_CTRL_ADD    = 5'h00;
    localparam logic [4:0] ALU_CTRL_SUB    = 5'h01;
    localparam logic [4:0] ALU_CTRL_AND    = 5'h02;
    localparam logic [4:0] ALU_CTRL_OR     = 5'h03;
    localparam logic [4:0] ALU_CTRL_XOR    = 5'h04;
    localparam logic [4:0] ALU_CTRL_SLL    = 5'h05;
    localparam logic [4:0] ALU_CTRL_SRL    = 5'h06;
    localparam logic [4:0] ALU_CTRL_SRA    = 5'h07;
    localparam logic [4:0] ALU_CTRL_SLT    = 5'h08;
    localparam logic [4:0] ALU_CTRL_SLTU   = 5'h09;
    localparam logic [4:0] ALU_CTRL_MUL    = 5'h10;
    localparam logic [4:0] ALU_CTRL_MULH   = 5'h11;
    localparam logic [4:0] ALU_CTRL_MULHSU = 5'h12;
    localparam logic [4:0] ALU_CTRL_MULHU  = 5'h13;
    localparam logic [4:0] ALU_CTRL_DIV    = 5'h14;
    localparam logic [4:0] ALU_CTRL_DIVU   = 5'h15;
    localparam logic [4:0] ALU_CTRL_REM    = 5'h16;
    localparam logic [4:0] ALU_CTRL_REMU   = 5'h17;

`ifdef ALU_MC_FAST_MUL_EN
    typedef enum logic [1:0] {IDLE, DIV} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`endif

    // Callers pass the operand sign-extended to 64 bits and truncate the result.
    function automatic logic [63:0] abs_val(input logic [63:0] x, input logic is_signed);
        return (is_signed && x[63]) ? -x : x;
    endfunction

endpackage

// File: rtl/alu_mc_div.sv
// rtl/alu_mc_div.sv - unsigned restoring divider, one quotient bit per cycle.
// The first step is taken on the load edge, so XLEN steps finish XLEN-1 cycles later.
module alu_mc_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] dvs;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] src_rem, src_quo, src_dvs, new_rem, new_quo;
    logic [XLEN:0]   shifted, diff;

    always_comb begin
        src_rem = load ? '0 : remainder;
        src_quo = load ? dividend : quotient;
        src_dvs = load ? divisor : dvs;
        shifted = {src_rem, src_quo[XLEN-1]};
        diff    = shifted - {1'b0, src_dvs};
        // A borrow out of bit XLEN means the trial subtraction failed; restore.
        new_rem = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        new_quo = {src_quo[XLEN-2:0], ~diff[XLEN]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            cnt       <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (load) begin
            busy      <= 1'b1;
            cnt       <= CW'(1);
            dvs       <= divisor;
            quotient  <= new_quo;
            remainder <= new_rem;
        end else if (busy) begin
            cnt       <= cnt + CW'(1);
            quotient  <= new_quo;
            remainder <= new_rem;
            if (cnt == CW'(XLEN - 1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle RV32I/RV64I + M-extension ALU with start/ready/done handshake.
// ALU_MC_FAST_MUL_EN selects a single-cycle combinational multiplier.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      ctrl,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] res,
    output logic            zero
);

    state_t state, state_nxt;
    logic [SHAMT_W-1:0] cnt;
    logic accept, is_mul, is_div, op1_signed, op2_signed, sign_diff;
    logic div_zero, div_ovf, div_special, div_load, div_busy, last_iter, wr_en;
    logic div_neg_q, div_neg_r, div_rem;
    logic [XLEN-1:0] a_mag, b_mag, base_res, spec_res, imm_res, wr_val;
    logic [XLEN-1:0] quotient, remainder, div_res, mul_res;
    logic [2*XLEN-1:0] prod_mag, prod;
    logic m_neg, m_hi;

    assign ready      = (state == IDLE);
    assign accept     = start && ready;
    assign is_mul     = (ctrl[4:2] == 3'b100);
    assign is_div     = (ctrl[4:2] == 3'b101);
    assign op1_signed = (ctrl == ALU_CTRL_MULH) || (ctrl == ALU_CTRL_MULHSU) ||
                        (ctrl == ALU_CTRL_DIV)  || (ctrl == ALU_CTRL_REM);
    assign op2_signed = (ctrl == ALU_CTRL_MULH) || (ctrl == ALU_CTRL_DIV) ||
                        (ctrl == ALU_CTRL_REM);
    assign a_mag      = XLEN'(abs_val(64'($signed(op1)), op1_signed));
    assign b_mag      = XLEN'(abs_val(64'($signed(op2)), op2_signed));
    assign sign_diff  = (op1_signed & op1[XLEN-1]) ^ (op2_signed & op2[XLEN-1]);

    assign div_zero    = (op2 == '0);
    assign div_ovf     = ((ctrl == ALU_CTRL_DIV) || (ctrl == ALU_CTRL_REM)) &&
                         (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign div_special = is_div && (div_zero || div_ovf);
    assign div_load    = accept && is_div && !div_special;
    // ctrl[1] separates REM/REMU from DIV/DIVU.
    assign spec_res    = div_zero ? (ctrl[1] ? op1 : '1) : (ctrl[1] ? '0 : op1);

    always_comb begin
        base_res = '0;
        case (ctrl)
            ALU_CTRL_ADD:  base_res = op1 + op2;
            ALU_CTRL_SUB:  base_res = op1 - op2;
            ALU_CTRL_AND:  base_res = op1 & op2;
            ALU_CTRL_OR:   base_res = op1 | op2;
            ALU_CTRL_XOR:  base_res = op1 ^ op2;
            ALU_CTRL_SLL:  base_res = op1 << op2[SHAMT_W-1:0];
            ALU_CTRL_SRL:  base_res = op1 >> op2[SHAMT_W-1:0];
            ALU_CTRL_SRA:  base_res = $signed(op1) >>> op2[SHAMT_W-1:0];
            ALU_CTRL_SLT:  base_res = XLEN'($signed(op1) < $signed(op2));
            ALU_CTRL_SLTU: base_res = XLEN'(op1 < op2);
            default:       base_res = '0;
        endcase
    end

`ifdef ALU_MC_FAST_MUL_EN
    assign prod_mag = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign m_neg    = sign_diff;
    assign m_hi     = (ctrl != ALU_CTRL_MUL);
`else
    logic [2*XLEN-1:0] mul_acc, mul_mcand;
    logic [XLEN-1:0]   mul_mplier;
    logic              mul_neg, mul_hi;

    // Final partial product is folded in combinationally on the exit edge.
    assign prod_mag = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign m_neg    = mul_neg;
    assign m_hi     = mul_hi;
`endif
    assign prod    = m_neg ? -prod_mag : prod_mag;
    assign mul_res = m_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    assign div_res = div_rem ? (div_neg_r ? -remainder : remainder)
                             : (div_neg_q ? -quotient : quotient);

    always_comb begin
        imm_res = '0;
        if (!ctrl[4])
            imm_res = base_res;
        else if (is_div)
            imm_res = spec_res;
`ifdef ALU_MC_FAST_MUL_EN
        else if (is_mul)
            imm_res = mul_res;
`endif
    end

    alu_mc_div #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (div_busy),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_val    = imm_res;
        last_iter = (cnt == SHAMT_W'(XLEN - 1));
        case (state)
            IDLE: begin
`ifndef ALU_MC_FAST_MUL_EN
                if (accept && is_mul)
                    state_nxt = MUL;
`endif
                if (div_load)
                    state_nxt = DIV;
                wr_en = accept && (state_nxt == IDLE);
            end
`ifndef ALU_MC_FAST_MUL_EN
            MUL: begin
                wr_val = mul_res;
                if (last_iter) begin
                    state_nxt = IDLE;
                    wr_en     = 1'b1;
                end
            end
`endif
            DIV: begin
                wr_val = div_res;
                if (last_iter && !div_busy) begin
                    state_nxt = IDLE;
                    wr_en     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            done      <= 1'b0;
            res       <= '0;
            zero      <= 1'b1;
            div_neg_q <= 1'b0;
            div_neg_r <= 1'b0;
            div_rem   <= 1'b0;
`ifndef ALU_MC_FAST_MUL_EN
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_neg    <= 1'b0;
            mul_hi     <= 1'b0;
`endif
        end else begin
            done <= wr_en;
            if (wr_en) begin
                res  <= wr_val;
                zero <= (wr_val == '0);
            end
            cnt <= (state == IDLE) ? '0 : cnt + SHAMT_W'(1);
            if (accept) begin
                div_neg_q <= sign_diff;
                div_neg_r <= op1_signed & op1[XLEN-1];
                div_rem   <= ctrl[1];
            end
`ifndef ALU_MC_FAST_MUL_EN
            if (accept) begin
                mul_acc    <= '0;
                mul_mcand  <= {{XLEN{1'b0}}, a_mag};
                mul_mplier <= b_mag;
                mul_neg    <= sign_diff;
                mul_hi     <= (ctrl != ALU_CTRL_MUL);
            end else if (state == MUL) begin
                mul_acc    <= prod_mag;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc; expected latencies follow ALU_MC_FAST_MUL_EN.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  ctrl = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        ready, done, zero;
    logic [31:0] res;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

`ifdef ALU_MC_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        zero;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    alu_mc #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ctrl  (ctrl),
        .op1   (op1),
        .op2   (op2),
        .ready (ready),
        .done  (done),
        .res   (res),
        .zero  (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: res=%h at cycle %0d, no result pending", res, cyc);
            end else begin
                e = sb.pop_front();
                if (res !== e.res || zero !== e.zero || cyc != e.due) begin
                    miscompares++;
                    $display("FAIL %s: got res=%h zero=%b cycle=%0d, expected res=%h zero=%b cycle=%0d",
                             e.name, res, zero, cyc, e.res, e.zero, e.due);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    task automatic issue(input string nm, input logic [4:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input int lat,
                         input bit push);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_ready_timeout: ready=%b after %0d cycles, expected 1", nm, ready, n);
        end
        ctrl  = c;
        op1   = a;
        op2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push)
            sb.push_back('{nm, r, (r == 32'h0), cyc + lat - 1});
    endtask

    // Watches the 32 busy cycles after an accept; optionally pokes a start that must be ignored.
    task automatic busy_window(input string nm, input bit inject);
        int highs = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (ready)
                highs++;
            if (inject && i == 5) begin
                ctrl  = ALU_CTRL_ADD;
                op1   = 32'd1;
                op2   = 32'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check({nm, "_ready_low"}, 32'(highs), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_res", res, 32'h0);
        check("reset_zero", 32'(zero), 32'd1);
        check("reset_done", 32'(done), 32'd0);

        issue("add", ALU_CTRL_ADD, 32'd5, 32'hFFFF_FFFD, 32'd2, 1, 1);
        @(negedge clk);
        check("add_ready_held", 32'(ready), 32'd1);

        issue("sub", ALU_CTRL_SUB, 32'd7, 32'd7, 32'd0, 1, 1);
        issue("sltu", ALU_CTRL_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1, 1);
        issue("xor", ALU_CTRL_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1, 1);
        issue("sll", ALU_CTRL_SLL, 32'd1, 32'd33, 32'd2, 1, 1);
        issue("sra", ALU_CTRL_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 1);
        issue("slt", ALU_CTRL_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1);
        issue("undef_0a", 5'h0A, 32'd5, 32'd3, 32'd0, 1, 1);
        issue("undef_18", 5'h18, 32'd5, 32'd3, 32'd0, 1, 1);

        issue("mulh", ALU_CTRL_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, 1);
        issue("mulhu", ALU_CTRL_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, MUL_LAT, 1);
        issue("mulhsu", ALU_CTRL_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, 1);
        issue("mul", ALU_CTRL_MUL, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, MUL_LAT, 1);

        issue("div", ALU_CTRL_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1);
        busy_window("div", 0);
        issue("rem", ALU_CTRL_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1);
        busy_window("rem", 0);
        issue("divu", ALU_CTRL_DIVU, 32'd100, 32'd7, 32'd14, 33, 1);
        busy_window("divu", 1);
        issue("remu", ALU_CTRL_REMU, 32'd100, 32'd7, 32'd2, 33, 1);

        issue("abort_div", ALU_CTRL_DIV, 32'd100, 32'd7, 32'd0, 33, 0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_res", res, 32'h0);
        check("abort_zero", 32'(zero), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        repeat (40) @(negedge clk);

        issue("divu_by0", ALU_CTRL_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 1);
        issue("rem_by0", ALU_CTRL_REM, 32'd9, 32'd0, 32'd9, 1, 1);
        issue("div_ovf", ALU_CTRL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        issue("rem_ovf", ALU_CTRL_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1);

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: no done observed, expected res=%h", e.name, e.res);
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
